id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 32-bit CPU core; sits directly upstream of the ALU and drives its a, b and alu_control inputs.
- Captures decoded operands and control each cycle.
- Resolves RAW hazards by forwarding results from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts bubbles; supports stall and flush from the hazard and branch logic.

Parameters:
DATA_W, 32, datapath width (ALU operand width)
REG_ADDR_W, 5, register index width
CNT_W, 16, bubble counter width (used only with the optional feature)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous reset, active-high
id_valid  input  1  decode stage holds a real instruction
id_rs1  input  REG_ADDR_W  source register 1 index
id_rs2  input  REG_ADDR_W  source register 2 index
id_rd  input  REG_ADDR_W  destination register index
id_rs1_data  input  DATA_W  register-file read data 1
id_rs2_data  input  DATA_W  register-file read data 2
id_imm  input  DATA_W  sign-extended immediate
id_alu_src  input  1  1 = ALU b takes the immediate
id_alu_control  input  3  ALU op (010 ADD, 110 SUB, 000 AND)
id_reg_write  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load
id_mem_write  input  1  instruction is a store
stall  input  1  hold stage contents
flush  input  1  kill stage contents (branch taken)
exmem_reg_write  input  1  EX/MEM instruction writes rd
exmem_rd  input  REG_ADDR_W  EX/MEM destination register
exmem_result  input  DATA_W  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB instruction writes rd
memwb_rd  input  REG_ADDR_W  MEM/WB destination register
memwb_data  input  DATA_W  MEM/WB write-back data
ex_valid  output  1  EX holds a real instruction
alu_a  output  DATA_W  ALU operand a
alu_b  output  DATA_W  ALU operand b
alu_control  output  3  registered ALU op
ex_rd  output  REG_ADDR_W  registered rd
ex_reg_write  output  1  registered reg_write, gated by ex_valid
ex_mem_read  output  1  registered mem_read, gated by ex_valid
ex_mem_write  output  1  registered mem_write, gated by ex_valid
ex_store_data  output  DATA_W  forwarded rs2 value for stores
load_use_hazard  output  1  combinational; upstream must hold IF/ID this cycle

Behaviour:
- Reset (asynchronous, any time, including mid-stall): every stage register clears to 0. Outputs: ex_valid=0, alu_control=000, ex_rd=0, all control bits 0, and alu_a/alu_b/ex_store_data=0 (no forwarding match is possible with rd 0).
- load_use_hazard = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Register update at each rising edge, in priority order:
  1. flush=1: load a bubble.
  2. stall=1: hold all fields.
  3. load_use_hazard=1: load a bubble.
  4. Otherwise: capture all id_* fields, with ex_valid<=id_valid.
- Bubble: ex_valid=0, reg_write/mem_read/mem_write=0, alu_control=000, rd=0; data fields are don't-care but are driven to 0.
- Forwarding is combinational on the registered fields, with separate selects for A (rs1) and B (rs2):
  - EX/MEM match (exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs) selects exmem_result.
  - Otherwise a MEM/WB match under the same conditions selects memwb_data.
  - Otherwise the registered read data is used.
  - EX/MEM has priority when both stages match.
  - Register 0 never forwards.
- alu_a = fwdA. alu_b = registered alu_src ? registered imm : fwdB. ex_store_data = fwdB always.
- Latency: an id_* value presented in cycle N appears at the ALU inputs in cycle N+1.
- Simultaneous events: flush overrides both a held stall and a hazard. A stall during a hazard holds; the hazard re-evaluates the next cycle.

Optional Feature:
- Macro ID_EX_BUBBLE_CNT_EN.
- Defined: adds output bubble_count [CNT_W-1:0].
  - Increments on each edge where a bubble is loaded because of load_use_hazard or flush.
  - Saturates at all-ones.
  - Clears on reset.
  - Does not change on stall.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset asserted mid-operation with ex_valid=1 -> all outputs 0 immediately, without waiting for a clock edge.
- ADD r3 (rs1 data 5, rs2 data 7, alu_control 010), no forwarding -> next cycle alu_a=5, alu_b=7, ex_rd=3, ex_reg_write=1.
- exmem_rd=3, exmem_result=0x10 and memwb_rd=3, memwb_data=0x20, with EX rs1=3 -> alu_a=0x10. With exmem_rd=0 instead -> alu_a=0x20. With rs1=0 -> registered data.
- Load to r4 in EX, ID rs2=4 -> load_use_hazard=1; next cycle ex_valid=0, ex_reg_write=0; the ID instruction is captured the cycle after.
- flush and stall both high with a valid EX instruction -> bubble loaded. stall alone -> fields unchanged for 3 cycles.
- With ID_EX_BUBBLE_CNT_EN: 2 hazards + 1 flush -> bubble_count=3. With CNT_W=2 and 5 bubbles -> bubble_count=3 (saturated).

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand capture, EX/MEM + MEM/WB forwarding, load-use bubbles.
// Optional bubble counter port enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]     id_rs1_data,
  input  logic [DATA_W-1:0]     id_rs2_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_alu_src,
  input  logic [2:0]            id_alu_control,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_data,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [2:0]            alu_control,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic                  load_use_hazard
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0]      bubble_count
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     rs1_data;
    logic [DATA_W-1:0]     rs2_data;
    logic [DATA_W-1:0]     imm;
    logic                  alu_src;
    logic [2:0]            alu_control;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } id_ex_t;

  id_ex_t id_pkt;
  id_ex_t ex_q;
  id_ex_t ex_d;

  assign id_pkt = '{
    valid:       id_valid,
    rs1:         id_rs1,
    rs2:         id_rs2,
    rd:          id_rd,
    rs1_data:    id_rs1_data,
    rs2_data:    id_rs2_data,
    imm:         id_imm,
    alu_src:     id_alu_src,
    alu_control: id_alu_control,
    reg_write:   id_reg_write,
    mem_read:    id_mem_read,
    mem_write:   id_mem_write
  };

  assign load_use_hazard = ex_q.valid & ex_q.mem_read
                         & (ex_q.rd != '0) & id_valid
                         & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

  // Flush beats stall; a stalled hazard is simply held and re-checked.
  always_comb begin
    ex_d = ex_q;
    priority case (1'b1)
      flush:           ex_d = '0;
      stall:           ex_d = ex_q;
      load_use_hazard: ex_d = '0;
      default:         ex_d = id_pkt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  logic hit_em_a;
  logic hit_wb_a;
  logic hit_em_b;
  logic hit_wb_b;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  assign hit_em_a = exmem_reg_write & (exmem_rd != '0)
                  & (exmem_rd == ex_q.rs1);
  assign hit_wb_a = memwb_reg_write & (memwb_rd != '0)
                  & (memwb_rd == ex_q.rs1);
  assign hit_em_b = exmem_reg_write & (exmem_rd != '0)
                  & (exmem_rd == ex_q.rs2);
  assign hit_wb_b = memwb_reg_write & (memwb_rd != '0)
                  & (memwb_rd == ex_q.rs2);

  // EX/MEM is the younger result, so it wins over MEM/WB.
  assign fwd_a = hit_em_a ? exmem_result
               : hit_wb_a ? memwb_data
               : ex_q.rs1_data;
  assign fwd_b = hit_em_b ? exmem_result
               : hit_wb_b ? memwb_data
               : ex_q.rs2_data;

  assign ex_valid      = ex_q.valid;
  assign alu_a         = fwd_a;
  assign alu_b         = ex_q.alu_src ? ex_q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign alu_control   = ex_q.alu_control;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
  assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
  assign ex_mem_write  = ex_q.valid & ex_q.mem_write;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic bump;

  assign bump = flush | (~stall & load_use_hazard);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bubble_count <= '0;
    else if (bump && !(&bubble_count))
      bubble_count <= bubble_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table, directed stall/flush/hazard runs,
// then random stimulus against an instruction-level reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        src;
    logic [2:0]  ctl;
    logic        rw;
    logic        mr;
    logic        mw;
  } ins_t;

  typedef struct packed {
    ins_t        in;
    logic        emw;
    logic [4:0]  emd;
    logic [31:0] emr;
    logic        wbw;
    logic [4:0]  wbd;
    logic [31:0] wbv;
    logic        hz;
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
  } vec_t;

  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b110;
  localparam logic [2:0] AND = 3'b000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  ins_t id = '0;
  logic exmem_rw = 1'b0;
  logic memwb_rw = 1'b0;
  logic [4:0] exmem_rd = '0;
  logic [4:0] memwb_rd = '0;
  logic [31:0] exmem_res = '0;
  logic [31:0] memwb_data = '0;

  logic        ex_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [31:0] ex_store_data;
  logic        load_use_hazard;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_count;
  logic [1:0]  bc2;
  logic        s_v, s_rw, s_mr, s_mw, s_hz;
  logic [31:0] s_a, s_b, s_sd;
  logic [2:0]  s_ctl;
  logic [4:0]  s_rd;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id.valid), .id_rs1(id.rs1), .id_rs2(id.rs2),
    .id_rd(id.rd), .id_rs1_data(id.d1), .id_rs2_data(id.d2),
    .id_imm(id.imm), .id_alu_src(id.src),
    .id_alu_control(id.ctl), .id_reg_write(id.rw),
    .id_mem_read(id.mr), .id_mem_write(id.mw),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_rw), .exmem_rd(exmem_rd),
    .exmem_result(exmem_res),
    .memwb_reg_write(memwb_rw), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
    .load_use_hazard(load_use_hazard)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .bubble_count(bubble_count)
`endif
  );

`ifdef ID_EX_BUBBLE_CNT_EN
  id_ex_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset),
    .id_valid(id.valid), .id_rs1(id.rs1), .id_rs2(id.rs2),
    .id_rd(id.rd), .id_rs1_data(id.d1), .id_rs2_data(id.d2),
    .id_imm(id.imm), .id_alu_src(id.src),
    .id_alu_control(id.ctl), .id_reg_write(id.rw),
    .id_mem_read(id.mr), .id_mem_write(id.mw),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_rw), .exmem_rd(exmem_rd),
    .exmem_result(exmem_res),
    .memwb_reg_write(memwb_rw), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data),
    .ex_valid(s_v), .alu_a(s_a), .alu_b(s_b),
    .alu_control(s_ctl), .ex_rd(s_rd),
    .ex_reg_write(s_rw), .ex_mem_read(s_mr),
    .ex_mem_write(s_mw), .ex_store_data(s_sd),
    .load_use_hazard(s_hz), .bubble_count(bc2)
  );
`endif

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_fwd();
    exmem_rw = 1'b0; exmem_rd = '0; exmem_res = '0;
    memwb_rw = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  function automatic ins_t mk(
    input logic v, input logic [4:0] s1, input logic [4:0] s2,
    input logic [4:0] d, input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] im, input logic sr, input logic [2:0] c,
    input logic w, input logic r, input logic m);
    ins_t t;
    t.valid = v; t.rs1 = s1; t.rs2 = s2; t.rd = d;
    t.d1 = a; t.d2 = b; t.imm = im; t.src = sr; t.ctl = c;
    t.rw = w; t.mr = r; t.mw = m;
    return t;
  endfunction

  function automatic vec_t mkv(
    input ins_t in, input logic emw, input logic [4:0] emd,
    input logic [31:0] emr, input logic wbw, input logic [4:0] wbd,
    input logic [31:0] wbv, input logic hz, input logic v,
    input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
    input logic [4:0] rd, input logic rw, input logic mr);
    vec_t t;
    t.in = in; t.emw = emw; t.emd = emd; t.emr = emr;
    t.wbw = wbw; t.wbd = wbd; t.wbv = wbv; t.hz = hz;
    t.v = v; t.a = a; t.b = b; t.sd = sd; t.rd = rd;
    t.rw = rw; t.mr = mr;
    return t;
  endfunction

  // Reference forwarding: youngest producer of a nonzero register wins.
  function automatic logic [31:0] fwd(input logic [4:0] rs,
                                      input logic [31:0] d);
    if (exmem_rw && rs != 0 && exmem_rd == rs) return exmem_res;
    if (memwb_rw && rs != 0 && memwb_rd == rs) return memwb_data;
    return d;
  endfunction

  vec_t tv[7];
  ins_t m, nx;
  int mc;
  logic ehz;

  initial begin
    tv[0] = mkv(mk(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0,
                   ADD, 1'b1, 1'b0, 1'b0),
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                1'b1, 32'd5, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0);
    tv[1] = mkv(mk(1'b1, 5'd3, 5'd0, 5'd5, 32'hAA, 32'hBB, 32'd0, 1'b0,
                   SUB, 1'b1, 1'b0, 1'b0),
                1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20, 1'b0,
                1'b1, 32'h10, 32'hBB, 32'hBB, 5'd5, 1'b1, 1'b0);
    tv[2] = mkv(tv[1].in,
                1'b1, 5'd0, 32'h10, 1'b1, 5'd3, 32'h20, 1'b0,
                1'b1, 32'h20, 32'hBB, 32'hBB, 5'd5, 1'b1, 1'b0);
    tv[3] = mkv(mk(1'b1, 5'd0, 5'd3, 5'd6, 32'h33, 32'h44, 32'd0, 1'b0,
                   AND, 1'b1, 1'b0, 1'b0),
                1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20, 1'b0,
                1'b1, 32'h33, 32'h10, 32'h10, 5'd6, 1'b1, 1'b0);
    tv[4] = mkv(mk(1'b1, 5'd1, 5'd2, 5'd4, 32'h100, 32'h55, 32'd4, 1'b1,
                   ADD, 1'b1, 1'b1, 1'b0),
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                1'b1, 32'h100, 32'd4, 32'h55, 5'd4, 1'b1, 1'b1);
    tv[5] = mkv(mk(1'b1, 5'd7, 5'd4, 5'd8, 32'd1, 32'd2, 32'd0, 1'b0,
                   AND, 1'b1, 1'b0, 1'b0),
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    tv[6] = mkv(tv[5].in,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                1'b1, 32'd1, 32'd2, 32'd2, 5'd8, 1'b1, 1'b0);

    #1;
    chk("rst.valid", 32'(ex_valid), 32'd0);
    chk("rst.a", alu_a, 32'd0);
    chk("rst.rd", 32'(ex_rd), 32'd0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      id = tv[i].in;
      exmem_rw = tv[i].emw; exmem_rd = tv[i].emd; exmem_res = tv[i].emr;
      memwb_rw = tv[i].wbw; memwb_rd = tv[i].wbd; memwb_data = tv[i].wbv;
      #1;
      chk($sformatf("tv%0d.hz", i), 32'(load_use_hazard), 32'(tv[i].hz));
      tick();
      chk($sformatf("tv%0d.valid", i), 32'(ex_valid), 32'(tv[i].v));
      chk($sformatf("tv%0d.a", i), alu_a, tv[i].a);
      chk($sformatf("tv%0d.b", i), alu_b, tv[i].b);
      chk($sformatf("tv%0d.sd", i), ex_store_data, tv[i].sd);
      chk($sformatf("tv%0d.rd", i), 32'(ex_rd), 32'(tv[i].rd));
      chk($sformatf("tv%0d.rw", i), 32'(ex_reg_write), 32'(tv[i].rw));
      chk($sformatf("tv%0d.mr", i), 32'(ex_mem_read), 32'(tv[i].mr));
    end

    // Asynchronous reset mid-cycle with a valid instruction in EX.
    #2;
    reset = 1'b1;
    #1;
    chk("arst.valid", 32'(ex_valid), 32'd0);
    chk("arst.a", alu_a, 32'd0);
    chk("arst.b", alu_b, 32'd0);
    chk("arst.sd", ex_store_data, 32'd0);
    chk("arst.ctl", 32'(alu_control), 32'd0);
    chk("arst.rw", 32'(ex_reg_write), 32'd0);
    tick();
    reset = 1'b0;

    no_fwd();
    id = mk(1'b1, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22, 32'd0, 1'b0,
            ADD, 1'b1, 1'b0, 1'b0);
    tick();
    stall = 1'b1;
    id = mk(1'b1, 5'd5, 5'd6, 5'd10, 32'h99, 32'h98, 32'd0, 1'b0,
            SUB, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d.valid", i), 32'(ex_valid), 32'd1);
      chk($sformatf("stall%0d.a", i), alu_a, 32'h11);
      chk($sformatf("stall%0d.b", i), alu_b, 32'h22);
      chk($sformatf("stall%0d.rd", i), 32'(ex_rd), 32'd9);
    end
    flush = 1'b1;
    tick();
    chk("flst.valid", 32'(ex_valid), 32'd0);
    chk("flst.rd", 32'(ex_rd), 32'd0);
    chk("flst.rw", 32'(ex_reg_write), 32'd0);
    flush = 1'b0;
    stall = 1'b0;

    for (int k = 0; k < 2; k++) begin
      id = mk(1'b1, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'd8, 1'b1,
              ADD, 1'b1, 1'b1, 1'b0);
      tick();
      id = mk(1'b1, 5'd4, 5'd0, 5'd7, 32'd3, 32'd0, 32'd0, 1'b0,
              ADD, 1'b1, 1'b0, 1'b0);
      #1;
      chk($sformatf("luh%0d.hz", k), 32'(load_use_hazard), 32'd1);
      tick();
      chk($sformatf("luh%0d.valid", k), 32'(ex_valid), 32'd0);
      tick();
      chk($sformatf("luh%0d.rd", k), 32'(ex_rd), 32'd7);
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("cnt3", 32'(bubble_count), 32'd3);
    chk("cnt3.sat", 32'(bc2), 32'd3);
`endif

    reset = 1'b1;
    #1;
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("cnt.rst", 32'(bubble_count), 32'd0);
`endif
    tick();
    reset = 1'b0;
    m = '0;
    mc = 0;

    for (int n = 0; n < 600; n++) begin
      id.valid = ($urandom_range(0, 3) != 0);
      id.rs1 = 5'($urandom_range(0, 4));
      id.rs2 = 5'($urandom_range(0, 4));
      id.rd = 5'($urandom_range(0, 4));
      id.d1 = $urandom;
      id.d2 = $urandom;
      id.imm = $urandom;
      id.src = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: id.ctl = ADD;
        1: id.ctl = SUB;
        default: id.ctl = AND;
      endcase
      id.rw = 1'($urandom_range(0, 1));
      id.mr = ($urandom_range(0, 2) == 0);
      id.mw = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      exmem_rw = 1'($urandom_range(0, 1));
      exmem_rd = 5'($urandom_range(0, 4));
      exmem_res = $urandom;
      memwb_rw = 1'($urandom_range(0, 1));
      memwb_rd = 5'($urandom_range(0, 4));
      memwb_data = $urandom;
      #1;
      ehz = m.valid && m.mr && m.rd != 0 && id.valid
         && (m.rd == id.rs1 || m.rd == id.rs2);
      chk("rnd.valid", 32'(ex_valid), 32'(m.valid));
      chk("rnd.a", alu_a, fwd(m.rs1, m.d1));
      chk("rnd.b", alu_b, m.src ? m.imm : fwd(m.rs2, m.d2));
      chk("rnd.sd", ex_store_data, fwd(m.rs2, m.d2));
      chk("rnd.ctl", 32'(alu_control), 32'(m.ctl));
      chk("rnd.rd", 32'(ex_rd), 32'(m.rd));
      chk("rnd.rw", 32'(ex_reg_write), 32'(m.valid & m.rw));
      chk("rnd.mr", 32'(ex_mem_read), 32'(m.valid & m.mr));
      chk("rnd.mw", 32'(ex_mem_write), 32'(m.valid & m.mw));
      chk("rnd.hz", 32'(load_use_hazard), 32'(ehz));
`ifdef ID_EX_BUBBLE_CNT_EN
      chk("rnd.cnt", 32'(bubble_count), 32'(mc > 65535 ? 65535 : mc));
      chk("rnd.sat", 32'(bc2), 32'(mc > 3 ? 3 : mc));
`endif
      if (flush) begin
        nx = '0;
        mc++;
      end else if (stall) begin
        nx = m;
      end else if (ehz) begin
        nx = '0;
        mc++;
      end else begin
        nx = id;
      end
      tick();
      m = nx;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
